// File: rtl/phase_arb_pkg.sv
// Shared definitions for the intersection phase arbiter: phase indices,
// state encoding and the round-robin search helper.
package phase_arb_pkg;

    localparam int unsigned NUM_PH = 5;

    localparam logic [2:0] PH_NORD    = 3'd0;
    localparam logic [2:0] PH_EST     = 3'd1;
    localparam logic [2:0] PH_SUD     = 3'd2;
    localparam logic [2:0] PH_VEST    = 3'd3;
    localparam logic [2:0] PH_PIETONI = 3'd4;
    localparam logic [2:0] PH_NONE    = 3'd7;

    localparam logic [2:0] INIT      = 3'd0;
    localparam logic [2:0] ALLRED    = 3'd1;
    localparam logic [2:0] ARB       = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    // First set bit of pend searching from ptr+1 upward, wrapping 4 -> 0.
    // Returns ptr unchanged when nothing is pending.
    function automatic logic [2:0] rr_next(input logic [NUM_PH-1:0] pend,
                                           input logic [2:0]        ptr);
        logic [2:0]  k;
        logic [2:0]  idx3;
        logic        found;
        int unsigned idx;
        k     = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_PH; i++) begin
            idx  = (int'(ptr) + i) % NUM_PH;
            idx3 = idx[2:0];
            if (!found && pend[idx3]) begin
                k     = idx3;
                found = 1'b1;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/phase_arbiter_rr_sec_tick_gen.sv
// Free-running prescaler: o_tick is high for one cycle every DIV_FACTOR cycles.
module sec_tick_gen
    import phase_arb_pkg::*;
#(
    parameter int unsigned DIV_FACTOR = 10000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int unsigned CW = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV_FACTOR - 1));
    assign o_tick = w_wrap;

    // Count 0..DIV_FACTOR-1 and wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (w_wrap)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

endmodule

// File: rtl/phase_arbiter_rr.sv
// Demand-driven round-robin scheduler for the five intersection phases,
// with an all-red clearance interval between grants.
// Optional watchdog: define PHASE_ARB_WDOG_EN to fault a phase that never
// reports done within WDOG_SEC ticks.
module phase_arbiter_rr
    import phase_arb_pkg::*;
#(
    parameter int unsigned DIV_FACTOR  = 10000000,
    parameter int unsigned MIN_RED_SEC = 2,
    parameter int unsigned WDOG_SEC    = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_PH-1:0] req_i,
    input  logic [NUM_PH-1:0] recall_i,
    input  logic [NUM_PH-1:0] done_i,
    output logic [NUM_PH-1:0] enable_o,
    output logic [NUM_PH-1:0] clear_o,
    output logic [2:0]        active_o,
    output logic              served_o,
    output logic              fault_o
);

    localparam int unsigned TMAX = (MIN_RED_SEC > WDOG_SEC) ? MIN_RED_SEC : WDOG_SEC;
    localparam int unsigned TCW  = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    logic [2:0]        r_state;
    logic [2:0]        r_rr_ptr;
    logic [NUM_PH-1:0] r_pend;
    logic [NUM_PH-1:0] r_enable;
    logic [NUM_PH-1:0] r_clear;
    logic [2:0]        r_active;
    logic              r_served;
    logic [TCW-1:0]    r_tcnt;

    logic              w_tick;
    logic [2:0]        w_k;
    logic [NUM_PH-1:0] w_grant_1h;

    sec_tick_gen #(
        .DIV_FACTOR(DIV_FACTOR)
    ) u_tick (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .o_tick (w_tick)
    );

    // Round-robin pick and the one-hot grant issued this cycle in ARB.
    always_comb begin
        w_k        = rr_next(r_pend, r_rr_ptr);
        w_grant_1h = '0;
        if (r_state == ARB && r_pend != '0)
            w_grant_1h = NUM_PH'(1) << w_k;
    end

    // Pending demand: a grant beats a same-cycle request for that phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pend <= '0;
        else
            r_pend <= (r_pend | req_i | recall_i) & ~w_grant_1h;
    end

`ifdef PHASE_ARB_WDOG_EN
    logic r_fault;

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fault <= 1'b0;
        else if (r_state == WAIT_DONE && !done_i[r_active] && r_tcnt == TCW'(WDOG_SEC))
            r_fault <= 1'b1;
    end

    assign fault_o = r_fault;
`else
    assign fault_o = 1'b0;
`endif

    // Main sequencer: INIT -> ALLRED -> ARB -> WAIT_DONE -> ALLRED ...
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= INIT;
            r_rr_ptr <= PH_PIETONI;
            r_enable <= '0;
            r_clear  <= '0;
            r_active <= PH_NONE;
            r_served <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            r_clear  <= '0;
            r_served <= 1'b0;
            case (r_state)
                INIT: begin
                    r_clear <= '1;
                    r_tcnt  <= '0;
                    r_state <= ALLRED;
                end
                ALLRED: begin
                    if (r_tcnt == TCW'(MIN_RED_SEC))
                        r_state <= ARB;
                    else if (w_tick)
                        r_tcnt <= r_tcnt + TCW'(1);
                end
                ARB: begin
                    if (r_pend != '0) begin
                        r_enable <= w_grant_1h;
                        r_active <= w_k;
                        r_rr_ptr <= w_k;
                        r_tcnt   <= '0;
                        r_state  <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (done_i[r_active]) begin
                        r_enable <= '0;
                        r_clear  <= r_enable;
                        r_served <= 1'b1;
                        r_active <= PH_NONE;
                        r_tcnt   <= '0;
                        r_state  <= ALLRED;
                    end
`ifdef PHASE_ARB_WDOG_EN
                    else if (r_tcnt == TCW'(WDOG_SEC)) begin
                        r_enable <= '0;
                        r_clear  <= '1;
                        r_active <= PH_NONE;
                        r_state  <= FAULT;
                    end else if (w_tick) begin
                        r_tcnt <= r_tcnt + TCW'(1);
                    end
`endif
                end
`ifdef PHASE_ARB_WDOG_EN
                FAULT: begin
                    r_clear <= '1;
                end
`endif
                default: r_state <= INIT;
            endcase
        end
    end

    assign enable_o = r_enable;
    assign clear_o  = r_clear;
    assign active_o = r_active;
    assign served_o = r_served;

endmodule

// File: tb/tb_phase_arbiter_rr.sv
// Directed self-checking bench for phase_arbiter_rr (DIV_FACTOR=4,
// MIN_RED_SEC=2, WDOG_SEC=3). Honours PHASE_ARB_WDOG_EN for the watchdog test.
`timescale 1ns/1ps
module tb_phase_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req_i = '0;
    logic [4:0] recall_i = '0;
    logic [4:0] done_i = '0;
    logic [4:0] enable_o;
    logic [4:0] clear_o;
    logic [2:0] active_o;
    logic       served_o;
    logic       fault_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    phase_arbiter_rr #(
        .DIV_FACTOR (4),
        .MIN_RED_SEC(2),
        .WDOG_SEC   (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .recall_i(recall_i),
        .done_i  (done_i),
        .enable_o(enable_o),
        .clear_o (clear_o),
        .active_o(active_o),
        .served_o(served_o),
        .fault_o (fault_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req_i    = '0;
        recall_i = '0;
        done_i   = '0;
        step();
        step();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Waits for the next grant, checks it, optionally checks the clearance gap.
    task automatic wait_grant(input logic [4:0] exp_en, input logic [2:0] exp_act,
                              input bit chk_gap, input string name);
        int n;
        n = 0;
        while (enable_o == 5'b0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (enable_o === 5'b0) begin
            failures++;
            $display("FAIL %s_timeout enable_o=%b expected=%b", name, enable_o, exp_en);
        end else begin
            if (enable_o !== exp_en || active_o !== exp_act) begin
                failures++;
                $display("FAIL %s_grant enable_o=%b active_o=%0d expected enable=%b active=%0d",
                         name, enable_o, active_o, exp_en, exp_act);
            end
            if (chk_gap) begin
                checks++;
                if (n < 6 || n > 9) begin
                    failures++;
                    $display("FAIL %s_allred_gap cycles=%0d expected 6..9", name, n);
                end
            end
        end
    endtask

    // Signals done for phase k and checks the completion outputs.
    task automatic complete_phase(input int k, input string name);
        logic [4:0] exp_clr;
        exp_clr = 5'b00001 << k;
        done_i  = exp_clr;
        step();
        checks++;
        if (enable_o !== 5'b0 || clear_o !== exp_clr || served_o !== 1'b1 || active_o !== 3'd7) begin
            failures++;
            $display("FAIL %s_done enable=%b clear=%b served=%b active=%0d expected 00000 %b 1 7",
                     name, enable_o, clear_o, served_o, active_o, exp_clr);
        end
        done_i = '0;
        step();
        checks++;
        if (clear_o !== 5'b0 || served_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse_end clear=%b served=%b expected 00000 0", name, clear_o, served_o);
        end
    endtask

    task automatic test_reset();
        bit bad;
        rst_n = 1'b0;
        step();
        checks++;
        if (enable_o !== 5'b0 || clear_o !== 5'b0 || served_o !== 1'b0 ||
            fault_o !== 1'b0 || active_o !== 3'd7) begin
            failures++;
            $display("FAIL reset_vals enable=%b clear=%b served=%b fault=%b active=%0d expected 0 0 0 0 7",
                     enable_o, clear_o, served_o, fault_o, active_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        checks++;
        if (clear_o !== 5'h1F || enable_o !== 5'b0 || active_o !== 3'd7) begin
            failures++;
            $display("FAIL init_clear clear=%b enable=%b active=%0d expected 11111 00000 7",
                     clear_o, enable_o, active_o);
        end
        step();
        checks++;
        if (clear_o !== 5'b0) begin
            failures++;
            $display("FAIL init_clear_len clear=%b expected 00000", clear_o);
        end
        bad = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (enable_o !== 5'b0 || active_o !== 3'd7 || clear_o !== 5'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL idle_allred enable=%b active=%0d expected 00000 7", enable_o, active_o);
        end
    endtask

    task automatic test_skip_pending();
        do_reset();
        req_i = 5'b00101;
        step();
        req_i = '0;
        wait_grant(5'b00001, 3'd0, 1'b0, "skip_first");
        complete_phase(0, "skip_nord");
        wait_grant(5'b00100, 3'd2, 1'b1, "skip_second");
        complete_phase(2, "skip_sud");
    endtask

    task automatic test_round_robin();
        int k;
        do_reset();
        req_i = 5'h1F;
        for (int i = 0; i < 6; i++) begin
            k = i % 5;
            wait_grant(5'b00001 << k, 3'(k), i > 0, "rr");
            complete_phase(k, "rr");
        end
        req_i = '0;
    endtask

    task automatic test_foreign_done();
        bit bad;
        do_reset();
        req_i = 5'b00010;
        step();
        req_i = '0;
        wait_grant(5'b00010, 3'd1, 1'b0, "foreign");
        done_i = 5'b01000;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (enable_o !== 5'b00010 || active_o !== 3'd1 || served_o !== 1'b0 || clear_o !== 5'b0)
                bad = 1'b1;
        end
        done_i = '0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL foreign_done enable=%b active=%0d served=%b expected 00010 1 0",
                     enable_o, active_o, served_o);
        end
        // Same-phase request coincident with done must be served again.
        req_i = 5'b00010;
        complete_phase(1, "foreign_est");
        req_i = '0;
        wait_grant(5'b00010, 3'd1, 1'b1, "rearm");
        complete_phase(1, "rearm_est");
    endtask

    task automatic test_recall();
        do_reset();
        recall_i = 5'b10000;
        for (int i = 0; i < 3; i++) begin
            wait_grant(5'b10000, 3'd4, i > 0, "recall");
            complete_phase(4, "recall");
        end
        recall_i = '0;
    endtask

    task automatic test_watchdog();
        int n;
        bit bad;
        do_reset();
        req_i = 5'b00100;
        step();
        req_i = '0;
        wait_grant(5'b00100, 3'd2, 1'b0, "wdog");
`ifdef PHASE_ARB_WDOG_EN
        n = 0;
        while (fault_o !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (fault_o !== 1'b1 || clear_o !== 5'h1F || enable_o !== 5'b0 || active_o !== 3'd7) begin
            failures++;
            $display("FAIL wdog_fault fault=%b clear=%b enable=%b active=%0d expected 1 11111 00000 7",
                     fault_o, clear_o, enable_o, active_o);
        end
        checks++;
        if (n < 10 || n > 13) begin
            failures++;
            $display("FAIL wdog_latency cycles=%0d expected 10..13", n);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (fault_o !== 1'b1 || clear_o !== 5'h1F || enable_o !== 5'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL wdog_sticky fault=%b clear=%b enable=%b expected 1 11111 00000",
                     fault_o, clear_o, enable_o);
        end
`else
        n = 0;
        bad = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (enable_o !== 5'b00100 || fault_o !== 1'b0 || clear_o !== 5'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL hold_no_wdog enable=%b fault=%b expected 00100 0", enable_o, fault_o);
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        req_i = 5'b00001;
        step();
        req_i = '0;
        wait_grant(5'b00001, 3'd0, 1'b0, "async");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (enable_o !== 5'b0 || active_o !== 3'd7 || fault_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset enable=%b active=%0d fault=%b expected 00000 7 0",
                     enable_o, active_o, fault_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        checks++;
        if (clear_o !== 5'h1F || enable_o !== 5'b0) begin
            failures++;
            $display("FAIL async_restart clear=%b enable=%b expected 11111 00000", clear_o, enable_o);
        end
    endtask

    initial begin
        test_reset();
        test_skip_pending();
        test_round_robin();
        test_foreign_done();
        test_recall();
        test_watchdog();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
